// File: rtl/mdu.sv
// ---------------------------------------------------------------------------
// mdu -- multiply/divide unit for the execute stage.
//
// Computes mult/multu/div/divu results from the rs/rt operands and holds
// them in the architectural HI/LO registers. Real multiplier/divider latency
// is modelled with a busy window so the controller can stall dependent
// instructions. mthi/mtlo write HI/LO in a single cycle.
//
// Ports:
//   clk      in   1  system clock, rising-edge
//   reset    in   1  synchronous active-high reset; clears all state
//   start    in   1  one-cycle strobe issuing mdu_op
//   mdu_op   in   3  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi,
//                    6 mtlo, 7 reserved (none)
//   in_1     in  32  rs operand
//   in_2     in  32  rt operand
//   out_sel  in   1  0 selects LO, 1 selects HI onto mdu_out
//   busy     out  1  high while a mult/div is in flight
//   hi       out 32  HI register
//   lo       out 32  LO register
//   mdu_out  out 32  out_sel ? hi : lo (combinational)
// ---------------------------------------------------------------------------
module mdu #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  mdu_op,
    input  logic [31:0] in_1,
    input  logic [31:0] in_2,
    input  logic        out_sel,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] mdu_out
);

    localparam logic [2:0] OP_NONE  = 3'd0;
    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    localparam logic [CNT_W-1:0] MULT_CNT = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_CNT  = CNT_W'(DIV_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [31:0]      hi_q, hi_d;
    logic [31:0]      lo_q, lo_d;
    logic [31:0]      pend_hi_q, pend_hi_d;
    logic [31:0]      pend_lo_q, pend_lo_d;
    logic             pend_vld_q, pend_vld_d;   // cleared for divide-by-zero
    logic             busy_q, busy_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // ------------------------------------------------------------------
    // Arithmetic datapath (evaluated on the accepting cycle's operands)
    // ------------------------------------------------------------------
    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic [31:0] a_mag, b_mag, b_div_s, b_div_u;
    logic [31:0] q_mag, r_mag;
    logic [31:0] quot_s, rem_s;
    logic [31:0] quot_u, rem_u;
    logic        b_zero;

    always_comb begin
        // Sign-extend to 64 bits so the low 64 bits of the product are the
        // exact two's-complement result.
        prod_s = {{32{in_1[31]}}, in_1} * {{32{in_2[31]}}, in_2};
        prod_u = {32'd0, in_1} * {32'd0, in_2};

        b_zero  = (in_2 == 32'd0);

        // Signed divide through magnitudes: avoids tool-dependent behaviour
        // for 0x80000000 / -1, which wraps back to 0x80000000 here.
        a_mag   = in_1[31] ? (32'd0 - in_1) : in_1;
        b_mag   = in_2[31] ? (32'd0 - in_2) : in_2;
        // Divisor forced to 1 on zero so the divider never sees x/0; the
        // result is discarded in that case anyway.
        b_div_s = b_zero ? 32'd1 : b_mag;
        b_div_u = b_zero ? 32'd1 : in_2;

        q_mag   = a_mag / b_div_s;
        r_mag   = a_mag % b_div_s;
        quot_s  = (in_1[31] ^ in_2[31]) ? (32'd0 - q_mag) : q_mag;
        rem_s   = in_1[31] ? (32'd0 - r_mag) : r_mag;

        quot_u  = in_1 / b_div_u;
        rem_u   = in_1 % b_div_u;
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    logic accept;

    always_comb begin
        accept = start && !busy_q && (mdu_op != OP_NONE) && (mdu_op != 3'd7);
    end

    always_comb begin
        hi_d       = hi_q;
        lo_d       = lo_q;
        pend_hi_d  = pend_hi_q;
        pend_lo_d  = pend_lo_q;
        pend_vld_d = pend_vld_q;
        busy_d     = busy_q;
        cnt_d      = cnt_q;

        if (accept) begin
            case (mdu_op)
                OP_MULT: begin
                    pend_hi_d  = prod_s[63:32];
                    pend_lo_d  = prod_s[31:0];
                    pend_vld_d = 1'b1;
                    busy_d     = 1'b1;
                    cnt_d      = MULT_CNT;
                end
                OP_MULTU: begin
                    pend_hi_d  = prod_u[63:32];
                    pend_lo_d  = prod_u[31:0];
                    pend_vld_d = 1'b1;
                    busy_d     = 1'b1;
                    cnt_d      = MULT_CNT;
                end
                OP_DIV: begin
                    pend_hi_d  = rem_s;
                    pend_lo_d  = quot_s;
                    pend_vld_d = !b_zero;
                    busy_d     = 1'b1;
                    cnt_d      = DIV_CNT;
                end
                OP_DIVU: begin
                    pend_hi_d  = rem_u;
                    pend_lo_d  = quot_u;
                    pend_vld_d = !b_zero;
                    busy_d     = 1'b1;
                    cnt_d      = DIV_CNT;
                end
                OP_MTHI: hi_d = in_1;
                OP_MTLO: lo_d = in_1;
                default: ;
            endcase
        end else if (busy_q) begin
            // The edge that takes the counter from 1 to 0 commits the result
            // and drops busy, giving exactly N busy cycles.
            if (cnt_q == CNT_ONE) begin
                cnt_d      = '0;
                busy_d     = 1'b0;
                pend_vld_d = 1'b0;
                if (pend_vld_q) begin
                    hi_d = pend_hi_q;
                    lo_d = pend_lo_q;
                end
            end else begin
                cnt_d = cnt_q - CNT_ONE;
            end
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            hi_q       <= 32'd0;
            lo_q       <= 32'd0;
            pend_hi_q  <= 32'd0;
            pend_lo_q  <= 32'd0;
            pend_vld_q <= 1'b0;
            busy_q     <= 1'b0;
            cnt_q      <= '0;
        end else begin
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            pend_hi_q  <= pend_hi_d;
            pend_lo_q  <= pend_lo_d;
            pend_vld_q <= pend_vld_d;
            busy_q     <= busy_d;
            cnt_q      <= cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign busy    = busy_q;
    assign hi      = hi_q;
    assign lo      = lo_q;
    assign mdu_out = out_sel ? hi_q : lo_q;

endmodule

// File: tb/tb_mdu.sv
// ---------------------------------------------------------------------------
// tb_mdu -- self-checking bench for mdu.
// A table of {op, operands, expected HI/LO, expected busy cycles} drives the
// main checks; expected results go into a scoreboard queue at issue and are
// popped when the operation completes. Hand-written sequences cover the
// ignored-while-busy, mid-operation reset, reset-vs-start and back-to-back
// cases.
// ---------------------------------------------------------------------------
module tb_mdu;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  mdu_op;
    logic [31:0] in_1;
    logic [31:0] in_2;
    logic        out_sel;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] mdu_out;

    mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .mdu_op  (mdu_op),
        .in_1    (in_1),
        .in_2    (in_2),
        .out_sel (out_sel),
        .busy    (busy),
        .hi      (hi),
        .lo      (lo),
        .mdu_out (mdu_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] ehi;
        logic [31:0] elo;
        int          ecyc;
    } vec_t;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
    } res_t;

    localparam int NVEC = 14;
    vec_t vecs [NVEC];
    res_t sbq [$];

    int checks   = 0;
    int failures = 0;

    // Bench's view of the architectural HI/LO between operations
    logic [31:0] cur_hi = 32'd0;
    logic [31:0] cur_lo = 32'd0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    // Issue one op at the next negedge, count busy cycles with a bound,
    // check HI/LO hold during busy, then compare against the scoreboard.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] ehi, input logic [31:0] elo, input int ecyc);
        res_t r;
        int   cyc;
        @(negedge clk);
        start  = 1'b1;
        mdu_op = op;
        in_1   = a;
        in_2   = b;
        r.hi = ehi;
        r.lo = elo;
        sbq.push_back(r);
        @(posedge clk);
        #1;
        start  = 1'b0;
        mdu_op = 3'd0;
        cyc = 0;
        while (busy && cyc < 200) begin
            chk("hold_hi", hi, cur_hi);
            chk("hold_lo", lo, cur_lo);
            @(posedge clk);
            #1;
            cyc++;
        end
        chk("busy_cycles", 32'(cyc), 32'(ecyc));
        r = sbq.pop_front();
        chk("hi", hi, r.hi);
        chk("lo", lo, r.lo);
        out_sel = 1'b1;
        #1;
        chk("mdu_out_hi", mdu_out, r.hi);
        out_sel = 1'b0;
        #1;
        chk("mdu_out_lo", mdu_out, r.lo);
        cur_hi = r.hi;
        cur_lo = r.lo;
        $display("txn op=%0d a=%08h b=%08h hi=%08h lo=%08h busy_cycles=%0d", op, a, b, hi, lo, cyc);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;

        vecs[0]  = '{3'd1, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFFA, 5};
        vecs[1]  = '{3'd2, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 32'hFFFFFFFE, 5};
        vecs[2]  = '{3'd3, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 10};
        vecs[3]  = '{3'd4, 32'h00000007, 32'h00000002, 32'h00000001, 32'h00000003, 10};
        vecs[4]  = '{3'd3, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 10};
        vecs[5]  = '{3'd5, 32'h12345678, 32'h00000000, 32'h12345678, 32'h80000000, 0};
        vecs[6]  = '{3'd3, 32'h00000005, 32'h00000000, 32'h12345678, 32'h80000000, 10};
        vecs[7]  = '{3'd6, 32'hCAFEBABE, 32'h00000000, 32'h12345678, 32'hCAFEBABE, 0};
        vecs[8]  = '{3'd4, 32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF, 10};
        vecs[9]  = '{3'd3, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 10};
        vecs[10] = '{3'd1, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 5};
        vecs[11] = '{3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 5};
        vecs[12] = '{3'd0, 32'h11111111, 32'h22222222, 32'hFFFFFFFE, 32'h00000001, 0};
        vecs[13] = '{3'd7, 32'h33333333, 32'h44444444, 32'hFFFFFFFE, 32'h00000001, 0};

        reset   = 1'b1;
        start   = 1'b0;
        mdu_op  = 3'd0;
        in_1    = 32'd0;
        in_2    = 32'd0;
        out_sel = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_hi", hi, 32'd0);
        chk("reset_lo", lo, 32'd0);
        chk("reset_out", mdu_out, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Table-driven main function, issued back-to-back
        for (int i = 0; i < NVEC; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].ehi, vecs[i].elo, vecs[i].ecyc);
        end

        // mtlo pulsed during a div is ignored; div result lands in LO
        @(negedge clk);
        start  = 1'b1;
        mdu_op = 3'd3;
        in_1   = 32'd100;
        in_2   = 32'd7;
        @(posedge clk);
        #1;
        cyc = 0;
        while (busy && cyc < 200) begin
            if (cyc == 1) begin
                start  = 1'b1;
                mdu_op = 3'd6;
                in_1   = 32'h0000AAAA;
            end else begin
                start  = 1'b0;
                mdu_op = 3'd0;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        start  = 1'b0;
        mdu_op = 3'd0;
        chk("ignore_busy_cycles", 32'(cyc), 32'd10);
        chk("ignore_lo", lo, 32'd14);
        chk("ignore_hi", hi, 32'd2);
        $display("txn div_with_ignored_mtlo hi=%08h lo=%08h busy_cycles=%0d", hi, lo, cyc);

        // Reset in the middle of a mult aborts it without commit
        @(negedge clk);
        start  = 1'b1;
        mdu_op = 3'd1;
        in_1   = 32'd3;
        in_2   = 32'd5;
        @(posedge clk);
        #1;
        start  = 1'b0;
        mdu_op = 3'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("midreset_busy", {31'd0, busy}, 32'd0);
        chk("midreset_hi", hi, 32'd0);
        chk("midreset_lo", lo, 32'd0);
        reset = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        chk("midreset_nocommit_busy", {31'd0, busy}, 32'd0);
        chk("midreset_nocommit_lo", lo, 32'd0);
        $display("txn mid_op_reset hi=%08h lo=%08h busy=%0d", hi, lo, busy);
        cur_hi = 32'd0;
        cur_lo = 32'd0;

        // Reset and start at the same edge: reset wins
        run_op(3'd5, 32'h00000077, 32'd0, 32'h00000077, 32'd0, 0);
        @(negedge clk);
        reset  = 1'b1;
        start  = 1'b1;
        mdu_op = 3'd1;
        in_1   = 32'd3;
        in_2   = 32'd4;
        @(posedge clk);
        #1;
        chk("rst_start_busy", {31'd0, busy}, 32'd0);
        chk("rst_start_hi", hi, 32'd0);
        reset  = 1'b0;
        start  = 1'b0;
        mdu_op = 3'd0;
        repeat (7) @(posedge clk);
        #1;
        chk("rst_start_later_busy", {31'd0, busy}, 32'd0);
        chk("rst_start_later_lo", lo, 32'd0);
        $display("txn reset_with_start hi=%08h lo=%08h busy=%0d", hi, lo, busy);
        cur_hi = 32'd0;
        cur_lo = 32'd0;

        // Back-to-back: mtlo accepted on the first cycle busy is low
        run_op(3'd1, 32'd6, 32'd7, 32'd0, 32'd42, 5);
        run_op(3'd6, 32'h00000055, 32'd0, 32'd0, 32'h00000055, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mdu.md
Name: mdu

Overview:
- Multiply/divide unit sitting in the execute stage beside the ALU; consumes the two GRF read operands (rs, rt) and produces HI/LO.
- Multi-cycle: models real multiplier/divider latency with a busy handshake so the controller can stall dependent instructions.
- HI/LO readback (mfhi/mflo) feeds the write-back data mux alongside the ALU, DM and PC+4 paths.

Parameters:
- MULT_CYCLES, 5, cycles busy is held for mult/multu (must be >= 1)
- DIV_CYCLES, 10, cycles busy is held for div/divu (must be >= 1)

Ports:
- clk  input  1  system clock, all state updates on rising edge
- reset  input  1  synchronous, active-high; clears all state
- start  input  1  one-cycle strobe: issue the operation on mdu_op this cycle
- mdu_op  input  3  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved (treated as none)
- in_1  input  32  rs operand
- in_2  input  32  rt operand
- out_sel  input  1  0 selects LO, 1 selects HI onto mdu_out
- busy  output  1  high while a mult/div is in progress
- hi  output  32  HI register
- lo  output  32  LO register
- mdu_out  output  32  combinational: out_sel ? hi : lo

Behaviour:
- Reset (synchronous, active-high): hi=0, lo=0, busy=0, internal counter=0, pending result cleared. Reset wins over start at the same edge. Reset mid-operation aborts it; the pending result is never committed.
- Accept condition: start=1, busy=0, mdu_op in 1..6. With start=1 and busy=1, the unit ignores the request entirely, including mthi/mtlo; the controller is responsible for stalling.
- mult/multu/div/divu accepted at edge E:
  - Operands are latched and the result is computed into pending_hi/pending_lo at E.
  - busy=1 from E, counter=N, where N = MULT_CYCLES or DIV_CYCLES.
  - Each later edge decrements the counter. At the edge where the counter reaches 0, hi/lo take the pending values and busy falls at that same edge.
  - busy is therefore high for exactly N cycles. hi/lo keep their old values while busy.
- mult: signed 32x32 -> 64; hi=[63:32], lo=[31:0]. multu: same, unsigned.
- div: signed; lo=quotient truncated toward zero, hi=remainder with the sign of the dividend (in_1). 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0.
- divu: unsigned quotient to lo, remainder to hi.
- Divide by zero (in_2==0): busy still asserts for DIV_CYCLES, but hi/lo are left unchanged at completion.
- mthi/mtlo: hi<=in_1 (or lo<=in_1) at the accepting edge. Single cycle; busy is not asserted.
- mdu_op 0 or 7 with start=1: no effect.
- mdu_out is purely combinational from hi/lo and is valid during busy. It returns the old values; the controller stalls mfhi/mflo while busy.
- No start is ever lost except while busy or in reset; back-to-back ops are accepted on the first cycle busy is 0.

Test Plan:
- Reset, then start mult with in_1=0xFFFFFFFE (-2), in_2=3 -> busy high 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA; hi/lo stay 0 during busy.
- multu in_1=0xFFFFFFFF, in_2=2 -> after 5 cycles hi=0x00000001, lo=0xFFFFFFFE; mdu_out with out_sel=1 gives 0x00000001.
- div in_1=0xFFFFFFF9 (-7), in_2=2 -> busy 10 cycles; lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). divu 7/2 -> lo=3, hi=1.
- mthi 0x12345678 then div by 0 -> hi=0x12345678 persists after 10 busy cycles; lo unchanged.
- During a div, pulse start with mtlo 0xAAAA -> ignored; lo ends with the div result. Mid-op reset at cycle 4 -> busy=0, hi=lo=0 next cycle, and no later commit.
- Simultaneous start and reset -> reset wins, busy=0. Back-to-back mult then mtlo on the cycle busy drops -> both take effect in order.
